fifo_rd_stream: RTL and testbench
=================================

# fifo_rd_stream

Read-side drain stage that sits directly downstream of the synchronous FIFO DUT. It pops words from the FIFO's registered read port (one-cycle read latency) and presents them on a valid/ready stream to the next consumer. A two-entry skid buffer absorbs the read latency so that back-to-back words flow at one word per cycle. Pop and stall counters support coverage and debug.

## Interface
- DATA_WIDTH, 8, FIFO word width; must match the FIFO DUT.
- CNT_WIDTH, 16, width of the word and stall counters.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  when high, the block may issue new FIFO reads.
- clr  input  1  synchronous clear of both counters.
- empty  input  1  FIFO empty flag.
- rd_data  input  DATA_WIDTH  FIFO read data, valid the cycle after rd_en.
- rd_en  output  1  FIFO pop request.
- m_valid  output  1  stream word valid.
- m_ready  input  1  downstream accepts the word.
- m_data  output  DATA_WIDTH  stream word.
- word_cnt  output  CNT_WIDTH  words delivered (m_valid && m_ready); wraps modulo 2^CNT_WIDTH.
- stall_cnt  output  CNT_WIDTH  cycles with m_valid && !m_ready; saturates at all-ones.
- idle  output  1  high when the buffer is empty and no read is in flight.

## Operation
- State: `inflight` (1 bit, a read was issued last cycle), `count` (0..2 buffered words), two data entries with read/write pointers, and the two counters.
- pop = m_valid && m_ready.
- rd_en = rst_n && enable && !empty && (count + inflight − pop) < 2. The path from m_ready to rd_en is combinational by design; this path is what gives full throughput.
- inflight(next) = rd_en.
- When inflight is high, rd_data is written into the buffer at the write pointer. A write and a pop in the same cycle leave count unchanged.
- m_valid = (count != 0). m_data is the entry at the read pointer. The stream is a registered output with no bypass.
- Words leave in exactly FIFO order. No word is ever dropped or duplicated.
- Once m_valid is high, m_data is held stable until pop.
- enable low blocks new reads only. A word already in flight is still captured, and buffered words continue to drain.
- clr zeroes word_cnt and stall_cnt and takes priority over an increment in the same cycle.
- Overflow is impossible by construction: the issue rule guarantees count + inflight ≤ 2.

## Timing
- Reset values: rd_en 0, m_valid 0, m_data 0, word_cnt 0, stall_cnt 0, idle 1. The internal inflight, count and pointers are all 0.
- First-word latency:
  - rd_en in cycle N.
  - rd_data sampled at the end of cycle N+1.
  - m_valid high in cycle N+2.
- Steady state with m_ready held high and the FIFO non-empty: one rd_en and one pop every cycle, with count = 1 and inflight = 1.
- Back-pressure: if m_ready drops, at most one further read is issued. Reads then stop with count = 2, and resume the cycle a pop frees space.
- FIFO going empty: rd_en deasserts in the same cycle. The buffer drains and idle rises one cycle after the last pop.
- Reset asserted mid-operation: all outputs return to their reset values asynchronously, and any word in flight or buffered is discarded. The FIFO is reset by the same rst_n.

## Structure
- A shared package `fifo_stream_pkg` holds the DATA_WIDTH/CNT_WIDTH defaults, kept consistent with the FIFO defines, and a `skid_cnt_t` typedef (2-bit occupancy).
- One sub-module, `fifo_skid_buf`: the 2-entry buffer with count and pointers. The top level holds the issue logic, inflight and the counters.

## Test plan
- Reset, then push 0x11..0x18 into the FIFO with m_ready = 1:
  - rd_en first in cycle N, 0x11 on m_data at N+2.
  - Eight consecutive pops, in order.
  - word_cnt = 8, stall_cnt = 0, idle = 1 afterwards.
- FIFO holds 4 words, m_ready = 0 for 6 cycles, then 1:
  - Exactly 2 rd_en pulses during the stall, count reaches 2.
  - stall_cnt = 6 (m_valid high throughout).
  - All 4 words then delivered in order.
- enable dropped in the same cycle as an rd_en pulse:
  - The in-flight word is still delivered.
  - No further rd_en until enable returns.
- Random m_ready (50%) over 200 words:
  - Scoreboard shows identical order, no loss.
  - count + inflight never exceeds 2.
  - m_data stable while stalled.
- rst_n pulsed low while count = 2 and inflight = 1:
  - m_valid 0 immediately, counters 0, idle 1.
  - A fresh word after reset appears with latency 2.
- Counter limits with CNT_WIDTH = 4:
  - 17 pops → word_cnt = 1 (wrap).
  - 20 stall cycles → stall_cnt = 15 (saturate).
  - clr coincident with a pop → both counters 0.

Source files
------------

// File: rtl/fifo_stream_pkg.sv
// Shared parameters and types for the FIFO read-side stream stage.
// The width defaults track the FIFO DUT defines so both sides agree.
package fifo_stream_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_CNT_WIDTH  = 16;

    // Skid buffer occupancy: 0, 1 or 2 words.
    typedef logic [1:0] skid_cnt_t;

    localparam skid_cnt_t SKID_EMPTY = 2'd0;
    localparam skid_cnt_t SKID_DEPTH = 2'd2;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer that captures FIFO read data and presents it as a
// registered stream word; the issue logic upstream guarantees it never overflows.
module fifo_skid_buf
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data
);

    logic [DATA_WIDTH-1:0] mem_r [2];
    logic                  wr_ptr_r;
    logic                  rd_ptr_r;
    skid_cnt_t             count_r;
    skid_cnt_t             count_nxt_s;

    // Occupancy update: a simultaneous write and pop leaves the count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_en, pop})
            2'b10:   count_nxt_s = count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage, pointers and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= SKID_EMPTY;
        end else begin
            if (wr_en) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_nxt_s;
        end
    end

    // A write never lands on the head entry while it is valid, so m_data holds until pop.
    assign count   = count_r;
    assign m_valid = (count_r != SKID_EMPTY);
    assign m_data  = mem_r[rd_ptr_r];

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side drain stage: issues pops against a one-cycle-latency FIFO read
// port and streams the words out through a skid buffer, with pop/stall counters.
module fifo_rd_stream
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  clr,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    output logic                  idle
);

    logic                 inflight_r;
    logic [1:0]           count_s;
    logic                 pop_s;
    logic                 stall_s;
    logic [2:0]           occ_s;
    logic [CNT_WIDTH-1:0] word_cnt_r;
    logic [CNT_WIDTH-1:0] stall_cnt_r;
    logic [CNT_WIDTH-1:0] word_nxt_s;
    logic [CNT_WIDTH-1:0] stall_nxt_s;

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (inflight_r),
        .wr_data (rd_data),
        .pop     (pop_s),
        .count   (count_s),
        .m_valid (m_valid),
        .m_data  (m_data)
    );

    assign pop_s   = m_valid && m_ready;
    assign stall_s = m_valid && !m_ready;

    // Space left after this cycle's pop; m_ready reaches rd_en combinationally for full rate.
    assign occ_s = {1'b0, count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign rd_en = rst_n && enable && !empty && (occ_s < {1'b0, SKID_DEPTH});

    // A read issued this cycle returns data next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= rd_en;
        end
    end

    // Counter next-state: clear wins, words wrap, stalls saturate.
    always_comb begin
        word_nxt_s  = word_cnt_r;
        stall_nxt_s = stall_cnt_r;
        if (clr) begin
            word_nxt_s  = '0;
            stall_nxt_s = '0;
        end else begin
            if (pop_s) begin
                word_nxt_s = word_cnt_r + CNT_WIDTH'(1);
            end else begin
                word_nxt_s = word_cnt_r;
            end
            if (stall_s && (stall_cnt_r != {CNT_WIDTH{1'b1}})) begin
                stall_nxt_s = stall_cnt_r + CNT_WIDTH'(1);
            end else begin
                stall_nxt_s = stall_cnt_r;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_r  <= '0;
            stall_cnt_r <= '0;
        end else begin
            word_cnt_r  <= word_nxt_s;
            stall_cnt_r <= stall_nxt_s;
        end
    end

    assign word_cnt  = word_cnt_r;
    assign stall_cnt = stall_cnt_r;
    assign idle      = (count_s == SKID_EMPTY) && !inflight_r;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based FIFO model feeds two instances
// (default and 4-bit counters); a transaction-level scoreboard checks every cycle.
module tb_fifo_rd_stream;

    logic       clk = 1'b0;
    logic       rst_n, enable, clr, empty, m_ready;
    logic [7:0] rd_data;
    logic       rd_en, m_valid, idle;
    logic [7:0] m_data;
    logic [15:0] word_cnt, stall_cnt;
    logic       rd_en4, m_valid4, idle4;
    logic [7:0] m_data4;
    logic [3:0] word_cnt4, stall_cnt4;
    logic       push_en;
    logic [7:0] push_data;
    logic [7:0] mem [$];
    logic [7:0] exp_q [$];

    int tests = 0, errors = 0, cyc = 0;
    int issued, delivered, word_exp, stall_exp, prev_rd_en;
    logic prev_stall;
    logic [7:0] prev_data, first_pop_data;
    int rd_seen, pop_seen, stall_seen, first_rd, first_val, first_pop, last_pop;

    always #5 clk = ~clk;

    fifo_rd_stream dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr), .empty(empty),
        .rd_data(rd_data), .rd_en(rd_en), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .word_cnt(word_cnt), .stall_cnt(stall_cnt), .idle(idle)
    );

    fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr), .empty(empty),
        .rd_data(rd_data), .rd_en(rd_en4), .m_valid(m_valid4), .m_ready(m_ready),
        .m_data(m_data4), .word_cnt(word_cnt4), .stall_cnt(stall_cnt4), .idle(idle4)
    );

    // Synchronous FIFO model with registered read data.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem.delete();
            rd_data <= 8'h00;
            empty   <= 1'b1;
        end else begin
            if (push_en) mem.push_back(push_data);
            if (rd_en && mem.size() > 0) rd_data <= mem.pop_front();
            empty <= (mem.size() == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic phase_reset();
        rd_seen = 0; pop_seen = 0; stall_seen = 0;
        first_rd = -1; first_val = -1; first_pop = -1; last_pop = -1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        issued = 0; delivered = 0; word_exp = 0; stall_exp = 0;
        prev_rd_en = 0; prev_stall = 1'b0; prev_data = 8'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; push_en = 1'b0; clr = 1'b0;
        #1;
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_m_valid4", 32'(m_valid4), 32'd0);
        model_reset();
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle: check outputs against the transaction model, then advance.
    task automatic tick();
        int outst;
        logic pop, rd_exp;
        logic [7:0] exp_w;
        #1;
        outst = issued - delivered;
        chk("idle", 32'(idle), 32'(outst == 0));
        chk("m_valid", 32'(m_valid), 32'((outst - prev_rd_en) > 0));
        chk("word_cnt", 32'(word_cnt), 32'(word_exp % 65536));
        chk("stall_cnt", 32'(stall_cnt), 32'((stall_exp > 65535) ? 65535 : stall_exp));
        chk("word_cnt4", 32'(word_cnt4), 32'(word_exp % 16));
        chk("stall_cnt4", 32'(stall_cnt4), 32'((stall_exp > 15) ? 15 : stall_exp));
        if (prev_stall) chk("hold", 32'(m_data), 32'(prev_data));
        pop = m_valid && m_ready;
        rd_exp = enable && !empty && ((outst - (pop ? 1 : 0)) < 2);
        chk("rd_en", 32'(rd_en), 32'(rd_exp));
        chk("rd_en4", 32'(rd_en4), 32'(rd_exp));
        if (pop) begin
            chk("pop_known", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_w = exp_q.pop_front();
                chk("order", 32'(m_data), 32'(exp_w));
                chk("order4", 32'(m_data4), 32'(exp_w));
            end
            delivered++; word_exp++; pop_seen++;
            if (first_pop < 0) begin first_pop = cyc; first_pop_data = m_data; end
            last_pop = cyc;
        end
        if (m_valid && !m_ready) begin stall_exp++; stall_seen++; end
        if (clr) begin word_exp = 0; stall_exp = 0; end
        if (rd_en) begin
            issued++; rd_seen++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (m_valid && first_val < 0) first_val = cyc;
        if (push_en) exp_q.push_back(push_data);
        chk("occupancy", 32'((issued - delivered) <= 2), 32'd1);
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_rd_en = rd_en ? 1 : 0;
        @(posedge clk); @(negedge clk);
        cyc++;
    endtask

    initial begin
        enable = 1'b0; clr = 1'b0; m_ready = 1'b0; push_en = 1'b0; push_data = 8'h00;
        do_reset();

        // Streaming 0x11..0x18 with the consumer always ready.
        phase_reset();
        enable = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_en = 1'b1; push_data = 8'h11 + 8'(i);
            tick();
        end
        push_en = 1'b0;
        for (int k = 0; k < 30 && pop_seen < 8; k++) tick();
        chk("p1_pops", 32'(pop_seen), 32'd8);
        chk("p1_latency", 32'(first_val - first_rd), 32'd2);
        chk("p1_first", 32'(first_pop_data), 32'h11);
        chk("p1_back2back", 32'(last_pop - first_pop), 32'd7);
        chk("p1_word_cnt", 32'(word_cnt), 32'd8);
        chk("p1_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("p1_idle", 32'(idle), 32'd1);

        // Back-pressure: four words waiting, consumer stalled.
        do_reset();
        phase_reset();
        enable = 1'b0; m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_en = 1'b1; push_data = 8'($urandom);
            tick();
        end
        push_en = 1'b0; enable = 1'b1;
        for (int k = 0; k < 30 && stall_seen < 6; k++) tick();
        chk("p2_rd_pulses", 32'(rd_seen), 32'd2);
        chk("p2_buffered", 32'(issued - delivered), 32'd2);
        chk("p2_stall_cnt", 32'(stall_cnt), 32'd6);
        m_ready = 1'b1;
        for (int k = 0; k < 30 && pop_seen < 4; k++) tick();
        chk("p2_pops", 32'(pop_seen), 32'd4);
        chk("p2_word_cnt", 32'(word_cnt), 32'd4);

        // enable dropped right after a read issues.
        phase_reset();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_en = 1'b1; push_data = 8'hC0 + 8'(i);
            tick();
        end
        push_en = 1'b0; enable = 1'b1;
        tick();
        enable = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        chk("p3_rd_once", 32'(rd_seen), 32'd1);
        chk("p3_inflight_out", 32'(pop_seen), 32'd1);
        enable = 1'b1;
        for (int k = 0; k < 30 && pop_seen < 3; k++) tick();
        chk("p3_pops", 32'(pop_seen), 32'd3);

        // Random consumer and producer over 200 words.
        phase_reset();
        begin
            int pushed = 0;
            for (int k = 0; k < 6000 && pop_seen < 200; k++) begin
                push_en = (pushed < 200) && ($urandom_range(0, 99) < 70);
                push_data = 8'($urandom);
                if (push_en) pushed++;
                m_ready = 1'($urandom_range(0, 1));
                clr = ($urandom_range(0, 19) == 0);
                tick();
            end
        end
        push_en = 1'b0; clr = 1'b0;
        chk("p4_pops", 32'(pop_seen), 32'd200);
        chk("p4_leftover", 32'(exp_q.size()), 32'd0);

        // Reset pulse with the buffer full.
        do_reset();
        phase_reset();
        enable = 1'b1; m_ready = 1'b0;
        for (int k = 0; k < 20 && (issued - delivered) < 2; k++) begin
            push_en = (k < 3); push_data = 8'hE0 + 8'(k);
            tick();
        end
        push_en = 1'b0;
        chk("p5_full", 32'(issued - delivered), 32'd2);
        do_reset();
        phase_reset();
        m_ready = 1'b1;
        push_en = 1'b1; push_data = 8'h5A;
        tick();
        push_en = 1'b0;
        for (int k = 0; k < 20 && pop_seen < 1; k++) tick();
        chk("p5_pop", 32'(pop_seen), 32'd1);
        chk("p5_latency", 32'(first_val - first_rd), 32'd2);
        chk("p5_data", 32'(first_pop_data), 32'h5A);

        // Counter limits on the 4-bit instance.
        do_reset();
        phase_reset();
        enable = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            push_en = 1'b1; push_data = 8'(i);
            tick();
        end
        push_en = 1'b0;
        for (int k = 0; k < 40 && pop_seen < 17; k++) tick();
        chk("p6_wrap4", 32'(word_cnt4), 32'd1);
        chk("p6_word16", 32'(word_cnt), 32'd17);
        phase_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_en = 1'b1; push_data = 8'h70 + 8'(i);
            tick();
        end
        push_en = 1'b0;
        for (int k = 0; k < 40 && stall_seen < 20; k++) tick();
        chk("p6_sat4", 32'(stall_cnt4), 32'd15);
        chk("p6_stall16", 32'(stall_cnt), 32'd20);
        m_ready = 1'b1; clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("p6_clr_pop", 32'(pop_seen), 32'd1);
        chk("p6_clr_word", 32'(word_cnt), 32'd0);
        chk("p6_clr_stall", 32'(stall_cnt), 32'd0);
        chk("p6_clr_word4", 32'(word_cnt4), 32'd0);
        chk("p6_clr_stall4", 32'(stall_cnt4), 32'd0);
        for (int k = 0; k < 20 && pop_seen < 3; k++) tick();
        chk("p6_drain", 32'(pop_seen), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
